// File: rtl/wb_arbiter_pkg.sv
// Shared core types for the writeback arbiter: register/data widths and the
// write record carried through the multi-cycle result FIFO.
package wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam int NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_rec_t;

  function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    logic [NREGS-1:0] mask;
    mask     = '0;
    mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Strict-order result FIFO for load/multi-cycle writebacks; exposes per-entry
// valid bits and destination registers so the parent can build a pending mask.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  wb_rec_t                        push_rec,
  input  logic                           pop,
  output wb_rec_t                        head,
  output logic [$clog2(DEPTH):0]         count,
  output logic [DEPTH-1:0]               valid,
  output logic [DEPTH-1:0][REG_AW-1:0]   entry_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_rec_t          mem_q [DEPTH];
  wb_rec_t          mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             push_ok, pop_ok;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    push_ok  = push && (count_q != CW'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push_ok) begin
      mem_d[wr_ptr_q]   = push_rec;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head  = mem_q[rd_ptr_q];
    count = count_q;
    valid = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd[i] = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: single-cycle ALU results have priority,
// queued multi-cycle results drain when the ALU is idle or has starved them.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_stall,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [REG_AW-1:0]        lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  output logic                     w_regs_en,
  output logic [REG_AW-1:0]        w_regs_addr,
  output logic [XLEN-1:0]          w_regs_data,
  output logic [NREGS-1:0]         pending_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_rec_t                     head;
  wb_rec_t                     push_rec;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][REG_AW-1:0] entry_rd;
  logic                        push, pop, fifo_empty, starved;

  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              w_regs_en_q, w_regs_en_d;
  logic [REG_AW-1:0] w_regs_addr_q, w_regs_addr_d;
  logic [XLEN-1:0]   w_regs_data_q, w_regs_data_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .valid    (valid),
    .entry_rd (entry_rd)
  );

  // x0 results from the LSU are handshaken but never enqueued.
  always_comb begin
    fifo_empty    = (fifo_count == '0);
    lsu_ready     = rst && (fifo_count != CW'(DEPTH));
    push          = lsu_valid && lsu_ready && (lsu_rd != '0);
    push_rec.rd   = lsu_rd;
    push_rec.data = lsu_data;
    starved       = !fifo_empty && (starve_cnt_q == SW'(STARVE_LIMIT));
    pop           = !fifo_empty && (starved || !alu_valid);
    alu_stall     = rst && alu_valid && starved;

    w_regs_en_d   = 1'b0;
    w_regs_addr_d = '0;
    w_regs_data_d = '0;
    if (pop) begin
      w_regs_en_d   = 1'b1;
      w_regs_addr_d = head.rd;
      w_regs_data_d = head.data;
    end else if (alu_valid && (alu_rd != '0)) begin
      w_regs_en_d   = 1'b1;
      w_regs_addr_d = alu_rd;
      w_regs_data_d = alu_data;
    end

    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        pending_mask = pending_mask | rd_onehot(entry_rd[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q  <= '0;
      w_regs_en_q   <= 1'b0;
      w_regs_addr_q <= '0;
      w_regs_data_q <= '0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      w_regs_en_q   <= w_regs_en_d;
      w_regs_addr_q <= w_regs_addr_d;
      w_regs_data_q <= w_regs_data_d;
    end
  end

  assign w_regs_en   = w_regs_en_q;
  assign w_regs_addr = w_regs_addr_q;
  assign w_regs_data = w_regs_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based model of the writeback rules.
module tb_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        w_regs_en;
  logic [4:0]  w_regs_addr;
  logic [31:0] w_regs_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_stall    (alu_stall),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .w_regs_en    (w_regs_en),
    .w_regs_addr  (w_regs_addr),
    .w_regs_data  (w_regs_data),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of {rd,data} records, a blocked-head cycle
  // counter and the write the port should be showing this cycle.
  logic [36:0] mq[$];
  int          m_starve;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        alu_hold;
  logic        lsu_hold;
  int          stall_seen;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelMask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i][36:32]] = 1'b1;
    return m;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_starve = 0;
    m_wen    = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    alu_hold = 1'b0;
    lsu_hold = 1'b0;
  endtask

  // Inputs are already driven; compare at the falling edge, then advance
  // the model by one rising edge using the same inputs.
  task automatic runCycle();
    int          sz;
    bit          starved, ready, popped;
    logic [36:0] rec;
    @(negedge clk);
    sz      = mq.size();
    starved = (sz > 0) && (m_starve == STARVE_LIMIT);
    ready   = (sz < DEPTH);
    checkOutput("alu_stall", alu_stall, alu_valid && starved);
    checkOutput("lsu_ready", lsu_ready, ready);
    checkOutput("fifo_count", fifo_count, sz);
    checkOutput("pending_mask", pending_mask, modelMask());
    checkOutput("w_regs_en", w_regs_en, m_wen);
    if (m_wen) begin
      checkOutput("w_regs_addr", w_regs_addr, m_waddr);
      checkOutput("w_regs_data", w_regs_data, m_wdata);
    end
    if (alu_stall) stall_seen++;

    popped = 1'b0;
    if (sz > 0 && (starved || !alu_valid)) begin
      rec     = mq.pop_front();
      m_wen   = 1'b1;
      m_waddr = rec[36:32];
      m_wdata = rec[31:0];
      popped  = 1'b1;
    end else if (alu_valid && alu_rd != 0) begin
      m_wen   = 1'b1;
      m_waddr = alu_rd;
      m_wdata = alu_data;
    end else begin
      m_wen = 1'b0;
    end
    if (sz == 0 || popped) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;
    if (lsu_valid && ready && lsu_rd != 0) mq.push_back({lsu_rd, lsu_data});
    alu_hold = alu_valid && starved;
    lsu_hold = lsu_valid && !ready;
    @(posedge clk);
    #1;
  endtask

  task automatic driveCycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                            input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ld;
    runCycle();
  endtask

  // Random traffic that honours upstream hold rules on stall / not-ready.
  task automatic applyStimulus(input int cycles, input int alu_pct, input int lsu_pct, input int zero_pct);
    for (int n = 0; n < cycles; n++) begin
      if (!alu_hold) begin
        alu_valid = ($urandom_range(99) < alu_pct);
        alu_rd    = ($urandom_range(99) < zero_pct) ? 5'd0 : 5'($urandom_range(31, 1));
        alu_data  = $urandom();
      end
      if (!lsu_hold) begin
        lsu_valid = ($urandom_range(99) < lsu_pct);
        lsu_rd    = ($urandom_range(99) < zero_pct) ? 5'd0 : 5'($urandom_range(31, 1));
        lsu_data  = $urandom();
      end
      runCycle();
    end
  endtask

  // Asserted just after a rising edge so the falling-edge check proves the
  // clear happens without waiting for a clock.
  task automatic applyReset();
    rst       = 1'b0;
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd3;
    @(negedge clk);
    checkOutput("rst_w_regs_en", w_regs_en, 1'b0);
    checkOutput("rst_w_regs_addr", w_regs_addr, 5'd0);
    checkOutput("rst_w_regs_data", w_regs_data, 32'd0);
    checkOutput("rst_fifo_count", fifo_count, 3'd0);
    checkOutput("rst_pending_mask", pending_mask, 32'd0);
    checkOutput("rst_lsu_ready", lsu_ready, 1'b0);
    checkOutput("rst_alu_stall", alu_stall, 1'b0);
    modelReset();
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    rst       = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    stall_seen = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    applyReset();

    // Idle ALU draining three queued loads in order.
    driveCycle(0, 0, 0, 1, 5'd5, 32'h11);
    driveCycle(0, 0, 0, 1, 5'd6, 32'h22);
    driveCycle(0, 0, 0, 1, 5'd7, 32'h33);
    repeat (4) driveCycle(0, 0, 0, 0, 0, 0);

    // Continuous ALU traffic starves one load until the stall forces it out.
    stall_seen = 0;
    driveCycle(1, 5'd2, 32'h100, 1, 5'd9, 32'hAB);
    for (int i = 0; i < 14; i++) driveCycle(1, 5'd2, 32'h200 + i, 0, 0, 0);
    checkOutput("starve_stall_count", stall_seen, 1);

    // Fill the FIFO behind a busy ALU; the fifth offer must wait.
    for (int i = 0; i < 6; i++) driveCycle(1, 5'd3, 32'h300 + i, 1, 5'(10 + i), 32'h400 + i);
    checkOutput("full_count", fifo_count, 3'd4);
    while (lsu_hold) driveCycle(1, 5'd3, 32'h3FF, 1, lsu_rd, lsu_data);
    repeat (12) driveCycle(0, 0, 0, 0, 0, 0);

    // x0 on both sources: handshake completes, nothing is written.
    driveCycle(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    driveCycle(0, 0, 0, 1, 5'd0, 32'h1);
    driveCycle(0, 0, 0, 0, 0, 0);
    checkOutput("x0_count", fifo_count, 3'd0);

    applyStimulus(300, 30, 40, 10);
    applyStimulus(300, 90, 50, 10);

    // Reset with work queued, then a push on the first edge after release.
    for (int i = 0; i < 3; i++) driveCycle(1, 5'd4, 32'h500, 1, 5'(20 + i), 32'h600 + i);
    applyReset();
    driveCycle(0, 0, 0, 1, 5'd1, 32'h5);
    driveCycle(0, 0, 0, 0, 0, 0);
    driveCycle(0, 0, 0, 0, 0, 0);

    applyStimulus(400, 60, 60, 15);
    applyStimulus(200, 10, 90, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of entries in the load/multi-cycle result FIFO (power of two, 2..16).
REQ-002 Parameter STARVE_LIMIT, default 8, SHALL set how many consecutive cycles a FIFO head may be blocked before the ALU is stalled.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 alu_valid  input  1  single-cycle ALU result present this cycle.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 alu_stall  output  1  ALU result not accepted this cycle; upstream holds alu_valid/rd/data.
REQ-009 lsu_valid  input  1  multi-cycle (load/mul) result offered.
REQ-010 lsu_ready  output  1  FIFO can accept the offered result.
REQ-011 lsu_rd  input  5  multi-cycle destination register.
REQ-012 lsu_data  input  32  multi-cycle result.
REQ-013 w_regs_en  output  1  register-file write enable.
REQ-014 w_regs_addr  output  5  register-file write address.
REQ-015 w_regs_data  output  32  register-file write data.
REQ-016 pending_mask  output  32  bit n set while a FIFO entry targets xn.
REQ-017 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Write port outputs SHALL be registered: a source selected in cycle N appears on w_regs_* in cycle N+1 for exactly one cycle.
REQ-019 LSU handshake: transfer when lsu_valid && lsu_ready on a rising edge; lsu_ready = (fifo_count < DEPTH), with no combinational path from lsu_valid.
REQ-020 An LSU transfer with lsu_rd == 0 SHALL be accepted and discarded (not enqueued, no count change, no write).
REQ-021 Per-cycle selection: if starve_cnt == STARVE_LIMIT and FIFO non-empty, pop head and assert alu_stall; else if alu_valid, write ALU result; else if FIFO non-empty, pop head; else w_regs_en = 0 next cycle.
REQ-022 alu_stall SHALL be combinational and high only when alu_valid and the starvation condition hold together.
REQ-023 An ALU result with alu_rd == 0 SHALL produce no write but still occupy the write slot (FIFO not popped that cycle).
REQ-024 starve_cnt SHALL increment each cycle the FIFO is non-empty and not popped, saturate at STARVE_LIMIT, and clear on every pop or when the FIFO is empty.
REQ-025 Simultaneous push and pop SHALL keep fifo_count unchanged; push when full is impossible by REQ-019; push into an empty FIFO is not eligible for pop in the same cycle (head valid from N+1).
REQ-026 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strict FIFO.
REQ-027 pending_mask SHALL be the OR of one-hot(rd) over valid entries, updated in the same edge as push/pop.
REQ-028 Write-after-write ordering between ALU and FIFO results is the issue stage's job, via pending_mask; this block SHALL NOT reorder or cancel entries.

Reset
REQ-029 While rst is low: w_regs_en = 0, w_regs_addr = 0, w_regs_data = 0, fifo_count = 0, pending_mask = 0, starve_cnt = 0, and pointers = 0.
REQ-030 While rst is low, lsu_ready = 0 and alu_stall = 0. FIFO data storage need not be reset.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries immediately, with no partial write after release.
REQ-032 The first push SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-033 The register-address width (5), data width (32), and the write-record type (rd, data) SHALL live in the shared core package.
REQ-034 The FIFO SHALL be a sub-module, wb_fifo, parameterised by DEPTH and exposing push, pop, head, count, and the valid-entry vector used to build pending_mask.

Verification
REQ-035 Idle ALU, 3 LSU pushes (x5=0x11, x6=0x22, x7=0x33) -> writes x5, x6, x7 in consecutive cycles starting one cycle after each pop; pending_mask 0xE0 -> 0.
REQ-036 alu_valid held high continuously, 1 LSU push x9=0xAB -> after 8 blocked cycles, alu_stall is high for one cycle and x9=0xAB is written; the ALU write resumes next cycle.
REQ-037 Fill 4 entries with ALU busy -> lsu_ready = 0 and fifo_count = 4; 5th offer is held by upstream and accepted the cycle after the first pop.
REQ-038 LSU push with rd=0 and ALU alu_rd=0 -> no w_regs_en; fifo_count stays 0.
REQ-039 rst pulled low with 3 entries queued -> next cycle fifo_count = 0, pending_mask = 0, no writes; after release a push of x1=0x5 is written.
REQ-040 Simultaneous push and pop at count 2 -> count stays 2; pointer wrap over 10 pushes keeps order intact.
